// File: rtl/risc16_pkg.sv
// risc16_pkg: shared RiSC-16 sequencer states, wait codes and opcodes.
package risc16_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        WAIT   = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [1:0] WC_NONE  = 2'd0;
    localparam logic [1:0] WC_ONE   = 2'd1;
    localparam logic [1:0] WC_TWO   = 2'd2;
    localparam logic [1:0] WC_THREE = 2'd3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;
endpackage

// File: rtl/seq_instret_counter.sv
// seq_instret_counter: wrapping retired-instruction counter.
module seq_instret_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: multicycle RiSC-16 sequencer gating IR/PC/RF/DMEM write strobes.
// CYCLE_SEQ_INSTRET_EN builds the retired-instruction counter; otherwise instret is 0.
module cycle_sequencer
    import risc16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             stall,
    input  logic [1:0]       wait_cycle,
    input  logic             werf,
    input  logic             wedmem,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we_n,
    output logic             dmem_we_n,
    output logic             busy,
    output logic             instr_done,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);
    state_t     st_q, st_d;
    logic [1:0] cnt_q, cnt_d;
    logic       commit;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st_q  <= IDLE;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end

    // commit is only raised when unstalled, so every strobe below inherits the stall gate
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        commit = 1'b0;
        if (!stall)
            case (st_q)
                IDLE:   st_d = run ? FETCH : IDLE;
                FETCH:  st_d = DECODE;
                DECODE:
                    if (wait_cycle == WC_NONE) begin
                        commit = 1'b1;
                        st_d   = run ? FETCH : IDLE;
                    end else if (wait_cycle == WC_ONE) begin
                        st_d = WB;
                    end else begin
                        cnt_d = wait_cycle - WC_TWO;
                        st_d  = WAIT;
                    end
                WAIT:
                    if (cnt_q == 2'd0) st_d = WB;
                    else cnt_d = cnt_q - 2'd1;
                WB: begin
                    commit = 1'b1;
                    st_d   = run ? FETCH : IDLE;
                end
                default: st_d = IDLE;
            endcase
    end

    assign ir_we      = !stall && st_q == FETCH;
    assign pc_we      = commit;
    assign rf_we_n    = !commit || werf;
    assign dmem_we_n  = !commit || wedmem;
    assign instr_done = commit;
    assign busy       = st_q != IDLE;
    assign state      = st_q;

`ifdef CYCLE_SEQ_INSTRET_EN
    seq_instret_counter #(.W(CNT_W)) u_instret (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (commit),
        .cnt  (instret)
    );
`else
    assign instret = '0;
`endif
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: directed scoreboard bench for cycle_sequencer.
module tb_cycle_sequencer;
    import risc16_pkg::*;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n, run, stall, werf, wedmem;
    logic [1:0]    wait_cycle;
    logic          ir_we, pc_we, rf_we_n, dmem_we_n, busy, instr_done;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    typedef struct {
        logic [2:0]    st;
        logic          ir, pc, rf, dm, dn, bz;
        logic [CW-1:0] ic;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    cycle_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .stall(stall),
        .wait_cycle(wait_cycle), .werf(werf), .wedmem(wedmem),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we_n(rf_we_n), .dmem_we_n(dmem_we_n),
        .busy(busy), .instr_done(instr_done), .state(state), .instret(instret)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // one clock cycle: expected outputs from the spec pushed, then popped at the negedge
    task automatic tk(input state_t s, input bit c);
        exp_t e;
        e.st = s;
        e.ir = (s == FETCH) && !stall;
        e.pc = c;
        e.rf = c ? werf : 1'b1;
        e.dm = c ? wedmem : 1'b1;
        e.dn = c;
        e.bz = (s != IDLE);
`ifdef CYCLE_SEQ_INSTRET_EN
        e.ic = exp_cnt;
        if (c) exp_cnt = exp_cnt + 1'b1;
`else
        e.ic = '0;
`endif
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk("state",      16'(state),      16'(e.st));
        chk("ir_we",      16'(ir_we),      16'(e.ir));
        chk("pc_we",      16'(pc_we),      16'(e.pc));
        chk("rf_we_n",    16'(rf_we_n),    16'(e.rf));
        chk("dmem_we_n",  16'(dmem_we_n),  16'(e.dm));
        chk("instr_done", 16'(instr_done), 16'(e.dn));
        chk("busy",       16'(busy),       16'(e.bz));
        chk("instret",    16'(instret),    16'(e.ic));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; stall = 1'b0;
        wait_cycle = 2'd0; werf = 1'b1; wedmem = 1'b1;
        tk(IDLE, 0);
        tk(IDLE, 0);
        rst_n = 1'b1;
        tk(IDLE, 0);
        tk(IDLE, 0);

        // back-to-back zero-wait instructions
        run = 1'b1; werf = 1'b0;
        tk(IDLE, 0);
        for (int i = 0; i < 4; i++) begin
            tk(FETCH, 0);
            tk(DECODE, 1);
        end

        // wait code 2
        wait_cycle = 2'd2; wedmem = 1'b1;
        tk(FETCH, 0);
        tk(DECODE, 0);
        tk(WAIT, 0);
        tk(WB, 1);

        // wait code 1 with a 3-cycle stall in DECODE
        wait_cycle = 2'd1; werf = 1'b1; wedmem = 1'b0;
        tk(FETCH, 0);
        stall = 1'b1;
        tk(DECODE, 0);
        tk(DECODE, 0);
        tk(DECODE, 0);
        stall = 1'b0;
        tk(DECODE, 0);
        tk(WB, 1);

        // wait code 3, run dropped mid-instruction
        wait_cycle = 2'd3; wedmem = 1'b1;
        tk(FETCH, 0);
        tk(DECODE, 0);
        run = 1'b0;
        tk(WAIT, 0);
        tk(WAIT, 0);
        tk(WB, 1);
        tk(IDLE, 0);

        // asynchronous reset while in WAIT
        run = 1'b1; werf = 1'b0;
        tk(IDLE, 0);
        tk(FETCH, 0);
        tk(DECODE, 0);
        tk(WAIT, 0);
        rst_n = 1'b0; run = 1'b0; exp_cnt = '0;
        #1;
        chk("rst_async_state", 16'(state), 16'(IDLE));
        chk("rst_async_rf",    16'(rf_we_n), 16'd1);
        chk("rst_async_busy",  16'(busy),  16'd0);
        tk(IDLE, 0);
        rst_n = 1'b1;
        tk(IDLE, 0);
        tk(IDLE, 0);
        tk(IDLE, 0);

        // counter wrap: 2^CW + 1 instructions
        run = 1'b1; wait_cycle = 2'd0; werf = 1'b1; wedmem = 1'b1;
        tk(IDLE, 0);
        for (int i = 0; i < (1 << CW); i++) begin
            tk(FETCH, 0);
            tk(DECODE, 1);
        end
        tk(FETCH, 0);
        run = 1'b0;
        tk(DECODE, 1);
        tk(IDLE, 0);
`ifdef CYCLE_SEQ_INSTRET_EN
        chk("instret_wrap", 16'(instret), 16'd1);
`else
        chk("instret_off", 16'(instret), 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Multicycle instruction sequencer for the RiSC-16 FPGA core. It steps each instruction through fetch, decode, optional wait and commit phases, and sizes each instruction's length from the control unit's `wait_cycle` code. Write strobes (instruction register, PC, register file, data memory) are gated so they fire only in the correct phase. The block sits between the combinational control unit and the datapath registers and owns all architectural-state update timing.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single core clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `run`, input, 1: level; allows a new fetch to begin.
- `stall`, input, 1: level; freezes the sequencer and suppresses all strobes.
- `wait_cycle`, input, 2: extra-cycle code from the control unit, decoded from the current IR.
- `werf`, input, 1: register-file write request from the control unit, active-low.
- `wedmem`, input, 1: data-memory write request from the control unit, active-low.
- `ir_we`, output, 1: instruction-register load strobe.
- `pc_we`, output, 1: PC load strobe.
- `rf_we_n`, output, 1: gated register-file write, active-low.
- `dmem_we_n`, output, 1: gated data-memory write, active-low.
- `busy`, output, 1: high when state ≠ IDLE.
- `instr_done`, output, 1: one-cycle pulse in the commit cycle.
- `state`, output, 3: current state encoding, for debug.
- `instret`, output, CNT_W: count of retired instructions.

## Operation
States: IDLE, FETCH, DECODE, WAIT, WB. A 2-bit down-counter `cnt` supports the WAIT state.

- **IDLE**
  - `run` = 1 → FETCH. Otherwise stay in IDLE.
- **FETCH**
  - `ir_we` = 1.
  - → DECODE.
- **DECODE**
  - `wait_cycle` is valid in this state, because the IR is now loaded.
  - `wait_cycle` = 0: this cycle is the commit cycle (commit actions below). Next state is FETCH if `run` = 1, else IDLE.
  - `wait_cycle` = 1: → WB.
  - `wait_cycle` = 2 or 3: `cnt` ← `wait_cycle` − 2, → WAIT.
- **WAIT**
  - `cnt` = 0 → WB. Otherwise `cnt` ← `cnt` − 1, stay in WAIT.
- **WB**
  - This is the commit cycle.
  - Next state is FETCH if `run` = 1, else IDLE.

Commit-cycle actions (and only in the commit cycle):
- `pc_we` = 1.
- `rf_we_n` = `werf`.
- `dmem_we_n` = `wedmem`.
- `instr_done` = 1.
- `instret` increments.

In every non-commit cycle: `pc_we` = 0, `rf_we_n` = 1, `dmem_we_n` = 1, `instr_done` = 0.

`stall` = 1 in any state:
- State and `cnt` hold.
- `ir_we`, `pc_we` and `instr_done` are forced to 0.
- `rf_we_n` and `dmem_we_n` are forced to 1.
- `instret` holds.

Dropping `run` mid-instruction does not abort; the instruction completes and the sequencer then goes to IDLE.

`instret` wraps modulo 2^CNT_W with no saturation.

## Timing
- Instruction length = 2 + `wait_cycle` cycles, measured from the FETCH cycle to the commit cycle inclusive. This gives 2, 3, 4 and 5 cycles for codes 0–3.
- Back-to-back instructions with `run` held high: FETCH follows the commit cycle directly, with no bubble.
- IDLE → FETCH takes 1 cycle after `run` is sampled high.
- All strobe outputs are combinational from state, `cnt`, `wait_cycle`, `werf`, `wedmem` and `stall`. None are registered.
- Reset values:
  - state = IDLE, `cnt` = 0, `instret` = 0.
  - `ir_we` = 0, `pc_we` = 0, `instr_done` = 0, `busy` = 0.
  - `rf_we_n` = 1, `dmem_we_n` = 1.
- Reset asserted mid-instruction: state forces to IDLE immediately (asynchronously) and all strobes deassert in the same cycle. No partial commit occurs.
- After reset release, the first FETCH starts no earlier than the first rising edge at which `run` = 1.

## Configuration
- `CYCLE_SEQ_INSTRET_EN` defined: `instret` is a CNT_W-bit register that increments on every unstalled commit cycle.
- `CYCLE_SEQ_INSTRET_EN` undefined: no counter register is built and `instret` is tied to 0.

## Structure
- Shared package `risc16_pkg` holds:
  - the state enum (IDLE=0, FETCH=1, DECODE=2, WAIT=3, WB=4);
  - the wait-code constants;
  - the opcode constants shared with the control unit.
- Sub-module `seq_instret_counter` holds the counter, instantiated under the macro.
- The state register and the `cnt` counter live in the top module.

## Test plan
1. Hold `run` = 1, `wait_cycle` = 0, `werf` = 0. Required: FETCH, DECODE repeats with period 2; `rf_we_n` is low only in DECODE; `instr_done` pulses every 2nd cycle.
2. Hold `run` = 1, then drive `wait_cycle` = 2 with `werf` = 0 and `wedmem` = 1. Required: sequence FETCH, DECODE, WAIT, WB; `pc_we` and `rf_we_n` are active only in WB; `dmem_we_n` stays 1 throughout.
3. `wait_cycle` = 1, `wedmem` = 0, with `stall` = 1 for 3 cycles during DECODE. Required: state holds in DECODE for those 3 cycles; no strobes fire; then WB; `dmem_we_n` is low for exactly 1 cycle.
4. `wait_cycle` = 3. Required: FETCH, DECODE, WAIT, WAIT, WB, a total of 5 cycles.
5. Pull `rst_n` low in WAIT with `werf` = 0. Required: in the same cycle, state = IDLE, `rf_we_n` = 1, `busy` = 0. After release with `run` = 0, the block stays in IDLE.
6. With the macro defined, run 65537 instructions. Required: `instret` = 1 (wrapped). With the macro undefined, `instret` = 0 throughout.
